// File: rtl/jtsdram_bank_wr.sv
// jtsdram_bank_wr: sweeps 2^AW addresses and writes data_ref at coded_addr through a wr/ack/rdy handshake.
// The sweep is paced by LVBL or by a random gap, with one write in flight. Define JTSDRAM_WR_BYTEMASK_EN to enable byte masks.

module jtsdram_rnd(
   input  logic       rst,
   input  logic       clk,
   input  logic       adv,
   output logic [3:0] lfsr
);
   logic [15:0] state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= 16'hace1;
      else if (adv)
         state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
   end

   assign lfsr = state[3:0];
endmodule

module jtsdram_bank_wr #(
   parameter int AW   = 22,
   parameter int TOUT = 255
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          LVBL,
   input  logic          start,
   input  logic          slow,
   output logic [AW-1:0] cnt_addr,
   input  logic [AW-1:0] coded_addr,
   input  logic [15:0]   data_ref,
   output logic [AW-1:0] sdram_addr,
   output logic [15:0]   sdram_din,
   output logic [1:0]    sdram_wrmask,
   output logic          wr,
   input  logic          ack,
   input  logic          rdy,
   output logic          bad,
   output logic          done
);
   typedef enum logic [2:0] {IDLE, GAP, REQ, BUSY, NEXT, DONE} state_t;

   localparam logic [7:0] TOUT_M1 = 8'(TOUT - 1);

   state_t     st;
   logic [3:0] gap;
   logic [7:0] wdog;
   logic       pend_start;
   logic [3:0] lfsr;
   logic [1:0] mask_nx;
   logic       gap_done, go, tout, xfer_end, do_restart;

   jtsdram_rnd u_rnd(
      .rst  (rst),
      .clk  (clk),
      .adv  (1'b1),
      .lfsr (lfsr)
   );

`ifdef JTSDRAM_WR_BYTEMASK_EN
   always_comb begin
      case (cnt_addr[1:0])
         2'd1:    mask_nx = 2'b10;
         2'd2:    mask_nx = 2'b01;
         default: mask_nx = 2'b00;
      endcase
   end
`else
   assign mask_nx = 2'b00;
`endif

   assign gap_done = &gap;
   assign go       = slow ? gap_done : LVBL;
   // >= rather than == so a watchdog that already passed TOUT still fires
   assign tout     = wdog >= TOUT_M1;
   assign xfer_end = (st == REQ && ack && rdy) || (st == BUSY && rdy);

   // A start seen during a transaction waits until that transaction ends
   always_comb begin
      do_restart = 1'b0;
      case (st)
         IDLE, GAP, NEXT: do_restart = start;
         DONE:            do_restart = start | pend_start;
         REQ, BUSY:       do_restart = xfer_end & (start | pend_start);
         default:         do_restart = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= IDLE;
         cnt_addr     <= '0;
         sdram_addr   <= '0;
         sdram_din    <= 16'd0;
         sdram_wrmask <= 2'b00;
         wr           <= 1'b0;
         bad          <= 1'b0;
         done         <= 1'b0;
         gap          <= 4'd0;
         wdog         <= 8'd0;
         pend_start   <= 1'b0;
      end else begin
         if (!gap_done)
            gap <= gap + 4'd1;
         if ((st == REQ || st == BUSY) && start)
            pend_start <= 1'b1;
         if (do_restart) begin
            cnt_addr   <= '0;
            done       <= 1'b0;
            bad        <= 1'b0;
            pend_start <= 1'b0;
            wr         <= 1'b0;
            st         <= GAP;
         end else begin
            case (st)
               GAP: if (go) begin
                  sdram_addr   <= coded_addr;
                  sdram_din    <= data_ref;
                  sdram_wrmask <= mask_nx;
                  wr           <= 1'b1;
                  wdog         <= 8'd0;
                  st           <= REQ;
               end
               REQ: begin
                  if (wdog != 8'hff)
                     wdog <= wdog + 8'd1;
                  if (ack) begin
                     wr <= 1'b0;
                     st <= rdy ? NEXT : BUSY;
                  end else if (tout) begin
                     wr   <= 1'b0;
                     bad  <= 1'b1;
                     done <= 1'b1;
                     st   <= DONE;
                  end
               end
               BUSY: begin
                  if (wdog != 8'hff)
                     wdog <= wdog + 8'd1;
                  if (rdy)
                     st <= NEXT;
                  else if (tout) begin
                     bad  <= 1'b1;
                     done <= 1'b1;
                     st   <= DONE;
                  end
               end
               NEXT: begin
                  if (&cnt_addr) begin
                     done <= 1'b1;
                     st   <= DONE;
                  end else begin
                     cnt_addr <= cnt_addr + AW'(1);
                     gap      <= (!slow && LVBL) ? 4'hd : lfsr;
                     st       <= GAP;
                  end
               end
               DONE: wr <= 1'b0;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: doc/jtsdram_bank_wr.md
Name: jtsdram_bank_wr

Overview:
- Write-side companion of the SDRAM bank tester. Sweeps a bank address range and writes one 16-bit word per address from an external reference-pattern source (data_ref).
- Drives a wr/ack/rdy request handshake toward the SDRAM controller, paced by LVBL or by a pseudo-random gap.
- Leaves the bank filled so the read-only checker can verify it afterwards. Sits beside the bank readers in the tester top level, one instance per writable bank.

Parameters:
- AW, 22, address width of cnt_addr, coded_addr and sdram_addr.
- TOUT, 255, max cycles from wr rise to rdy before timeout (8-bit watchdog, saturating).

Ports:
- rst  in  1  reset; asynchronous, active-high.
- clk  in  1  clock.
- LVBL  in  1  vertical blank low; write gaps in fast mode wait for LVBL=1.
- start  in  1  one-cycle pulse: restart sweep from address 0.
- slow  in  1  1 = random gap pacing, 0 = LVBL pacing.
- cnt_addr  out  AW  linear sweep address (to external pattern/scrambler).
- coded_addr  in  AW  scrambled address for cnt_addr (combinational externally).
- data_ref  in  16  pattern word for cnt_addr.
- sdram_addr  out  AW  registered address presented with wr.
- sdram_din  out  16  registered write data.
- sdram_wrmask  out  2  byte mask, 1 = byte not written.
- wr  out  1  write request.
- ack  in  1  controller accepted request.
- rdy  in  1  write completed.
- bad  out  1  sticky timeout flag.
- done  out  1  sweep finished.

Behaviour:
- Reset values: cnt_addr=0, sdram_addr=0, sdram_din=0, sdram_wrmask=0, wr=0, bad=0, done=0, state IDLE, gap counter=0, watchdog=0, pend_start=0.
- Gap counter: 4-bit; "gap done" = all ones; increments while not all ones. Internal jtsdram_rnd instance, adv=1, supplies lfsr.
- FSM IDLE: wait for start; then cnt_addr=0, done=0, bad=0, go to GAP.
- FSM GAP: leave when (slow ? gap done : LVBL). On exit, latch sdram_addr<=coded_addr, sdram_din<=data_ref and the mask, assert wr, clear watchdog, go to REQ.
- FSM REQ: wr held high, addr/data/mask stable. On ack: wr<=0 next cycle, go to BUSY. If ack and rdy arrive in the same cycle, the transaction completes (go to NEXT).
- FSM BUSY: wait for rdy, then go to NEXT. addr/data stay stable until rdy.
- FSM NEXT (1 cycle):
  - If cnt_addr is all ones: done<=1, go to DONE.
  - Else cnt_addr+1. Reload gap counter with 4'hd when (!slow && LVBL), else with lfsr[3:0]. Go to GAP.
- FSM DONE: wr=0, done held until start.
- Watchdog: counts in REQ and BUSY. Reaching TOUT sets bad=1, drops wr, and goes to DONE with done=1. A late rdy/ack is then ignored.
- start while IDLE, GAP or DONE: restart immediately.
- start while REQ or BUSY: latched into pend_start. The current transaction runs to rdy (or timeout), then the sweep restarts at 0. wr never drops before ack.
- A start pulse on the same cycle as NEXT takes priority over the increment.
- Address arithmetic wraps modulo 2^AW. Termination is only on all-ones after its write completes, so exactly 2^AW writes per sweep.
- Reset mid-transaction: everything returns to reset values asynchronously. Controller recovery is the controller's responsibility.

Optional Feature:
- Macro: JTSDRAM_WR_BYTEMASK_EN.
- With the macro, the mask latched at request time is set from cnt_addr[1:0]:
  - 1 gives 2'b10 (low byte only).
  - 2 gives 2'b01 (high byte only).
  - 0 or 3 gives 2'b00.
- Without the macro, sdram_wrmask is constant 2'b00.

Test Plan:
- AW=4, slow=0, LVBL=1, ack 1 cycle after wr, rdy 3 cycles after ack -> 16 writes at addresses coded_addr(0..15), sdram_din=data_ref each, done=1 after 16th rdy, bad=0.
- LVBL=0 held 100 cycles after start -> wr stays 0; wr rises within 2 cycles of LVBL=1.
- ack and rdy asserted together in the same cycle -> wr drops next cycle, cnt_addr advances once, no double write.
- rdy withheld, TOUT=20 -> bad=1 and done=1 at 20 cycles after wr rise; later rdy ignored; next start clears bad.
- start pulsed while in BUSY at address 5 -> address 5 completes on rdy, next wr at coded_addr(0), sweep completes 16 writes.
- JTSDRAM_WR_BYTEMASK_EN defined -> masks 00,10,01,00 repeating for addresses 0..3; undefined -> 00 for all.
